// File: rtl/zion_basic_circuit_lib_flush_skid_slice_pkg.sv
// Shared types for the flush-capable two-entry skid slice.
package zion_skid_pkg;

    // Occupancy of the slice: nothing held, main register only, main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/zion_basic_circuit_lib_flush_skid_slice_if.sv
// Valid/ready handshake bundle for the skid slice; names are from the slice's point of view.
interface zion_basic_circuit_lib_flush_skid_slice_if #(
    parameter int unsigned WIDTH = 8
);
    logic             iFlush;
    logic             iVld;
    logic             oRdy;
    logic [WIDTH-1:0] iDat;
    logic             oVld;
    logic             iRdy;
    logic [WIDTH-1:0] oDat;

    modport slave (
        input  iFlush, iVld, iDat, iRdy,
        output oRdy, oVld, oDat
    );

    modport master (
        output iFlush, iVld, iDat, iRdy,
        input  oRdy, oVld, oDat
    );
endinterface

// File: rtl/zion_basic_circuit_lib_flush_skid_slice_sclr_dff.sv
// Data register with synchronous reset, synchronous clear and load enable.
module zion_basic_circuit_lib_sclr_dff #(
    parameter int unsigned          WIDTH    = 8,
    parameter logic [WIDTH-1:0]     INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iClr,
    input  logic             iEn,
    input  logic [WIDTH-1:0] iDat,
    output logic [WIDTH-1:0] oDat
);

    // Clear wins over load so a flush can never be overridden by a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            oDat <= INI_DATA;
        end else if (iClr) begin
            oDat <= INI_DATA;
        end else if (iEn) begin
            oDat <= iDat;
        end
    end

endmodule

// File: rtl/zion_basic_circuit_lib_flush_skid_slice.sv
// Two-entry valid/ready skid slice with synchronous flush; all handshake outputs registered.
module zion_basic_circuit_lib_flush_skid_slice
    import zion_skid_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic                                         clk,
    input  logic                                         rst,
    zion_basic_circuit_lib_flush_skid_slice_if.slave     bus
);

    if (WIDTH < 1) begin : g_bad_width
        $error("zion_basic_circuit_lib_flush_skid_slice: WIDTH must be >= 1");
    end
    if ($bits(INI_DATA) > WIDTH) begin : g_bad_ini
        $error("zion_basic_circuit_lib_flush_skid_slice: INI_DATA wider than WIDTH");
    end

    skid_state_e      state_q;
    skid_state_e      state_d;
    logic             vld_q;
    logic             rdy_q;
    logic             in_xfer;
    logic             out_xfer;
    logic             main_en;
    logic             main_clr;
    logic             skid_en;
    logic             skid_clr;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign in_xfer  = bus.iVld & rdy_q;
    assign out_xfer = vld_q & bus.iRdy;

    // Draining from TWO promotes the older skid beat; otherwise main loads from upstream.
    assign main_d = (state_q == TWO) ? skid_q : bus.iDat;

    // Next state and register controls; flush overrides every normal transition.
    always_comb begin
        state_d  = state_q;
        main_en  = 1'b0;
        main_clr = 1'b0;
        skid_en  = 1'b0;
        skid_clr = 1'b0;
        if (bus.iFlush) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d = ONE;
                        main_en = 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_en = 1'b1;
                    end else if (in_xfer) begin
                        state_d = TWO;
                        skid_en = 1'b1;
                    end else if (out_xfer) begin
                        state_d  = EMPTY;
                        main_clr = 1'b1;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        state_d  = ONE;
                        main_en  = 1'b1;
                        skid_clr = 1'b1;
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    // Ready is derived from the next state so there is no iRdy -> oRdy combinational path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= (state_d != EMPTY);
            rdy_q   <= (state_d != TWO);
        end
    end

    zion_basic_circuit_lib_sclr_dff #(
        .WIDTH    (WIDTH),
        .INI_DATA (INI_DATA)
    ) u_main (
        .clk  (clk),
        .rst  (rst),
        .iClr (main_clr),
        .iEn  (main_en),
        .iDat (main_d),
        .oDat (main_q)
    );

    zion_basic_circuit_lib_sclr_dff #(
        .WIDTH    (WIDTH),
        .INI_DATA (INI_DATA)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .iClr (skid_clr),
        .iEn  (skid_en),
        .iDat (bus.iDat),
        .oDat (skid_q)
    );

    assign bus.oVld = vld_q;
    assign bus.oRdy = rdy_q;
    assign bus.oDat = main_q;

endmodule

// File: tb/tb_zion_basic_circuit_lib_flush_skid_slice.sv
// Directed and random checks of the flush skid slice against a queue-based reference model.
module tb_zion_basic_circuit_lib_flush_skid_slice;

    localparam int unsigned WIDTH = 8;
    localparam logic [WIDTH-1:0] INI = 8'hA5;

    logic clk = 1'b0;
    logic rst;

    zion_basic_circuit_lib_flush_skid_slice_if #(.WIDTH(WIDTH)) bus ();

    zion_basic_circuit_lib_flush_skid_slice #(
        .WIDTH    (WIDTH),
        .INI_DATA (INI)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the slice is a FIFO of at most two beats.
    logic [WIDTH-1:0] mq[$];
    logic             m_rdy = 1'b0;
    int               m_deliv = 0;
    int               dut_deliv = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_dat();
        return (mq.size() > 0) ? mq[0] : INI;
    endfunction

    task automatic chk_all(input string tag);
        chk({tag, "_vld"}, 32'(bus.oVld), 32'(mq.size() > 0));
        chk({tag, "_rdy"}, 32'(bus.oRdy), 32'(m_rdy));
        chk({tag, "_dat"}, 32'(bus.oDat), 32'(exp_dat()));
    endtask

    // Called at a falling edge: drive inputs, advance the model, run one clock, land on next falling edge.
    task automatic step(input logic r, input logic fl, input logic v,
                        input logic [WIDTH-1:0] d, input logic rd);
        logic m_in;
        logic m_out;
        rst        = r;
        bus.iFlush = fl;
        bus.iVld   = v;
        bus.iDat   = d;
        bus.iRdy   = rd;
        if (!r && bus.oVld === 1'b1 && rd) dut_deliv++;
        m_in  = v & m_rdy;
        m_out = (mq.size() > 0) & rd;
        if (r) begin
            mq.delete();
            m_rdy = 1'b0;
        end else begin
            if (m_out) begin
                void'(mq.pop_front());
                m_deliv++;
            end
            if (fl) mq.delete();
            else if (m_in) mq.push_back(d);
            m_rdy = (mq.size() < 2);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [WIDTH-1:0] prev_dat;
        logic             prev_hold;
        rst        = 1'b1;
        bus.iFlush = 1'b0;
        bus.iVld   = 1'b0;
        bus.iDat   = '0;
        bus.iRdy   = 1'b0;

        // 1: reset held three cycles, ready appears one edge after release
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            chk("rst_vld", 32'(bus.oVld), 32'd0);
            chk("rst_rdy", 32'(bus.oRdy), 32'd0);
            chk("rst_dat", 32'(bus.oDat), 32'hA5);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("rel_rdy", 32'(bus.oRdy), 32'd1);
        chk_all("rel");

        // 2: back-to-back stream with downstream always ready
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'(i), 1'b1);
            chk("stream_dat", 32'(bus.oDat), 32'(i));
            chk("stream_vld", 32'(bus.oVld), 32'd1);
            chk("stream_rdy", 32'(bus.oRdy), 32'd1);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk_all("drain");
        chk("drain_idle_dat", 32'(bus.oDat), 32'hA5);

        // 3: fill to TWO under backpressure, then drain in order
        step(1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h22, 1'b0);
        chk("two_rdy", 32'(bus.oRdy), 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'h33, 1'b0);
        chk("two_hold_dat", 32'(bus.oDat), 32'h11);
        chk("two_hold_rdy", 32'(bus.oRdy), 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'h33, 1'b1);
        chk("order_22", 32'(bus.oDat), 32'h22);
        step(1'b0, 1'b0, 1'b1, 8'h33, 1'b1);
        chk("order_33", 32'(bus.oDat), 32'h33);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk_all("order_done");

        // 4: flush while TWO with a concurrent upstream beat
        step(1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h22, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h44, 1'b0);
        chk("flush_vld", 32'(bus.oVld), 32'd0);
        chk("flush_dat", 32'(bus.oDat), 32'hA5);
        chk("flush_rdy", 32'(bus.oRdy), 32'd1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("flush_no44", 32'(bus.oVld), 32'd0);
        chk_all("flush_after");

        // 5: flush coinciding with a downstream transfer still delivers that beat
        step(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("flushdeliv_vld", 32'(bus.oVld), 32'd0);
        chk("flushdeliv_cnt", 32'(dut_deliv), 32'(m_deliv));
        chk_all("flushdeliv");

        // 6: random traffic, flushes and occasional resets
        prev_hold = 1'b0;
        prev_dat  = '0;
        for (int i = 0; i < 10000; i++) begin
            logic r;
            logic fl;
            logic v;
            logic rd;
            r  = ($urandom_range(0, 499) == 0);
            fl = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 99) < 70);
            rd = ($urandom_range(0, 99) < 60);
            if (prev_hold) chk("rnd_stable", 32'(bus.oDat), 32'(prev_dat));
            prev_hold = (bus.oVld === 1'b1) && !rd && !fl && !r;
            prev_dat  = bus.oDat;
            step(r, fl, v, 8'($urandom), rd);
            chk_all("rnd");
        end
        chk("rnd_deliv_cnt", 32'(dut_deliv), 32'(m_deliv));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
